// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FiFo write port among NUM_REQ producers.
// Optional macro FIFO_WR_ARBITER_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
//
// state | meaning
// IDLE  | no owner; pick the first valid requester at or after rr_ptr
// BURST | owner streams up to MAX_BURST words into the FiFo

module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BUS_SIZE = 32,
  parameter int MAX_BURST     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_BUS_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               grant,
  input  logic                             fifo_full,
  output logic                             fifo_wr,
  output logic [DATA_BUS_SIZE-1:0]         fifo_data_in,
  output logic                             busy
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
  ,
  output logic [15:0]                      stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0]   LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [CNT_W-1:0]         burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]         sel_idx;
  logic                     sel_found;
  logic                     owner_valid;
  logic [DATA_BUS_SIZE-1:0] owner_data;
  logic                     do_release;

  // Round-robin scan starting at rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_BUS_SIZE +: DATA_BUS_SIZE];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    grant_d      = grant_q;
    req_ready    = '0;
    fifo_wr      = 1'b0;
    fifo_data_in = '0;
    do_release   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = BURST;
          owner_d     = sel_idx;
          grant_d     = ONE_HOT0 << sel_idx;
          burst_cnt_d = '0;
        end
      end

      BURST: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (owner_q == PTR_W'(i)) && !fifo_full;
        end
        fifo_wr      = owner_valid && !fifo_full;
        fifo_data_in = owner_data;

        // A gap in the owner's stream gives up the grant, even under backpressure.
        if (!owner_valid) begin
          do_release = 1'b1;
        end else if (fifo_wr) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == LAST_CNT) begin
            do_release = 1'b1;
          end
        end

        if (do_release) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      grant_q     <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BURST);

`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state_q == BURST) && owner_valid && fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
